// File: rtl/ddram_responder_if.sv
// DDRAM_* burst bus between a DDR client (master) and the on-chip responder (slave).
// Valid/ready: a command or write beat transfers on any rising edge where RD or WE is high and DDRAM_BUSY is low.
interface ddram_responder_if;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  modport master (
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );

  modport slave (
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
endinterface

// File: rtl/ddram_responder.sv
// BRAM-backed responder for the DDRAM_* burst bus: byte-enabled write bursts,
// fixed-latency read bursts, an address window check and injectable back-pressure.
module ddram_responder #(
  parameter int           ADDR_W     = 10,
  parameter logic [3:0]   BASE       = 4'b0011,
  parameter int           RD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ddram_responder_if.slave      ddr,
  input  logic                  stall,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WBURST = 2'd1;
  localparam logic [1:0] RWAIT  = 2'd2;
  localparam logic [1:0] RDATA  = 2'd3;

  logic [63:0]       mem [0:(2**ADDR_W)-1];
  logic [63:0]       mem_q;

  logic [1:0]        state_q, state_n;
  logic [7:0]        cnt_q, cnt_n;
  logic [3:0]        lat_q, lat_n;
  logic [ADDR_W-1:0] idx_q, idx_n;
  logic              w_oow_q, w_oow_n;
  logic              r_oow_q, r_oow_n;
  logic              busy_q, busy_n;
  logic              rdy_q, rdy_n;
  logic              err_q, err_n;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;

  logic              rd_acc, we_acc, in_win;
  logic [7:0]        bc_m1;
  logic [ADDR_W-1:0] a_idx;
  logic              unused_addr;

  assign rd_acc      = ddr.DDRAM_RD && !busy_q;
  assign we_acc      = ddr.DDRAM_WE && !busy_q;
  assign in_win      = (ddr.DDRAM_ADDR[28:25] == BASE);
  assign a_idx       = ddr.DDRAM_ADDR[ADDR_W-1:0];
  assign bc_m1       = (ddr.DDRAM_BURSTCNT == 8'd0) ? 8'd0 : ddr.DDRAM_BURSTCNT - 8'd1;
  assign unused_addr = ^ddr.DDRAM_ADDR[24:ADDR_W];

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    lat_n     = lat_q;
    idx_n     = idx_q;
    w_oow_n   = w_oow_q;
    r_oow_n   = r_oow_q;
    rdy_n     = 1'b0;
    err_n     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = idx_q;
    mem_raddr = idx_q;

    case (state_q)
      IDLE: begin
        if (we_acc) begin
          // A simultaneous read is dropped: the write wins and the conflict is flagged.
          mem_we    = in_win;
          mem_waddr = a_idx;
          w_oow_n   = !in_win;
          idx_n     = a_idx + 1'b1;
          cnt_n     = bc_m1;
          err_n     = rd_acc || !in_win;
          if (bc_m1 != 8'd0) state_n = WBURST;
        end else if (rd_acc) begin
          r_oow_n = !in_win;
          err_n   = !in_win;
          cnt_n   = bc_m1;
          if (RD_LATENCY == 1) begin
            mem_re    = 1'b1;
            mem_raddr = a_idx;
            idx_n     = a_idx + 1'b1;
            rdy_n     = 1'b1;
            state_n   = RDATA;
          end else begin
            idx_n   = a_idx;
            lat_n   = 4'(RD_LATENCY - 1);
            state_n = RWAIT;
          end
        end
      end
      WBURST: begin
        err_n = ddr.DDRAM_RD;
        if (we_acc) begin
          mem_we = !w_oow_q;
          idx_n  = idx_q + 1'b1;
          cnt_n  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_n = IDLE;
        end
      end
      RWAIT: begin
        lat_n = lat_q - 4'd1;
        // The BRAM output register adds one cycle, so beat 0 is fetched one count early.
        if (lat_q == 4'd1) begin
          mem_re  = 1'b1;
          idx_n   = idx_q + 1'b1;
          rdy_n   = 1'b1;
          state_n = RDATA;
        end
      end
      RDATA: begin
        if (cnt_q == 8'd0) begin
          state_n = IDLE;
        end else begin
          mem_re = 1'b1;
          idx_n  = idx_q + 1'b1;
          cnt_n  = cnt_q - 8'd1;
          rdy_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = stall || (state_n == RWAIT) || (state_n == RDATA);
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 8; b++) begin
        if (ddr.DDRAM_BE[b]) mem[mem_waddr][b*8 +: 8] <= ddr.DDRAM_DIN[b*8 +: 8];
      end
    end
    if (mem_re) mem_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      lat_q   <= 4'd0;
      idx_q   <= '0;
      w_oow_q <= 1'b0;
      r_oow_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      lat_q   <= lat_n;
      idx_q   <= idx_n;
      w_oow_q <= w_oow_n;
      r_oow_q <= r_oow_n;
      busy_q  <= busy_n;
      rdy_q   <= rdy_n;
      err_q   <= err_n;
    end
  end

  // Out-of-window reads still deliver every beat, just as zero data.
  assign ddr.DDRAM_DOUT       = (rdy_q && !r_oow_q) ? mem_q : 64'd0;
  assign ddr.DDRAM_DOUT_READY = rdy_q;
  assign ddr.DDRAM_BUSY       = busy_q;
  assign err                  = err_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_ddram_responder.sv
// Bench for ddram_responder: table of write/partial-write/read-back vectors,
// then hand sequences for read timing, stalled wrapping burst, conflict, window and reset.
module tb_ddram_responder;
  localparam logic [3:0] BASE = 4'b0011;
  localparam logic [1:0] IDLE = 2'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       err;
  logic [1:0] state_dbg;

  ddram_responder_if ifc ();

  ddram_responder #(.ADDR_W(10), .BASE(BASE), .RD_LATENCY(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ddr       (ifc),
    .stall     (stall),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model [0:1023];

  typedef struct {
    int          idx;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] addr_of(input logic [3:0] win, input int idx);
    logic [9:0] i10;
    i10 = idx[9:0];
    return {win, 15'd0, i10};
  endfunction

  // Scoreboard: every delivered read beat must match the oldest expected word.
  always @(negedge clk) begin
    if (ifc.DDRAM_DOUT_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected no beat", ifc.DDRAM_DOUT);
      end else begin
        chk("rd_beat", ifc.DDRAM_DOUT, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (ifc.DDRAM_BUSY !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("busy_timeout", 64'(ifc.DDRAM_BUSY), 64'd0);
  endtask

  task automatic write_single(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
    wait_not_busy();
    ifc.DDRAM_WE = 1'b1; ifc.DDRAM_ADDR = a; ifc.DDRAM_BURSTCNT = 8'd1;
    ifc.DDRAM_DIN = d; ifc.DDRAM_BE = be;
    step();
    ifc.DDRAM_WE = 1'b0;
  endtask

  task automatic issue_read(input logic [28:0] a, input logic [7:0] bc);
    wait_not_busy();
    ifc.DDRAM_RD = 1'b1; ifc.DDRAM_ADDR = a; ifc.DDRAM_BURSTCNT = bc;
    step();
    ifc.DDRAM_RD = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  initial begin
    vecs[0] = '{16,   64'hAAAA_BBBB_CCCC_DDDD, 64'h1122_3344_5566_7788, 8'hF0, 64'h1122_3344_CCCC_DDDD};
    vecs[1] = '{4,    64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{5,    64'h0000_0000_0000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0000_0000_CAFE_F00D};
    vecs[3] = '{100,  64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 64'hAA55_5555_5555_55AA};
    vecs[4] = '{1023, 64'h0000_0000_0000_0001, 64'hFF00_FF00_FF00_FF00, 8'hFF, 64'hFF00_FF00_FF00_FF00};

    reset = 1'b1; stall = 1'b0;
    ifc.DDRAM_RD = 1'b0; ifc.DDRAM_WE = 1'b0; ifc.DDRAM_ADDR = '0;
    ifc.DDRAM_BURSTCNT = 8'd0; ifc.DDRAM_DIN = '0; ifc.DDRAM_BE = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(ifc.DDRAM_BUSY), 64'd0);
    chk("rst_ready", 64'(ifc.DDRAM_DOUT_READY), 64'd0);
    chk("rst_dout", ifc.DDRAM_DOUT, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    step();

    // Full write, partial write, then single-beat read-back per vector.
    for (int i = 0; i < 5; i++) begin
      write_single(addr_of(BASE, vecs[i].idx), vecs[i].d0, 8'hFF);
      write_single(addr_of(BASE, vecs[i].idx), vecs[i].d1, vecs[i].be);
      @(negedge clk);
      chk("wr_err", 64'(err), 64'd0);
      model[vecs[i].idx] = vecs[i].exp;
      exp_q.push_back(vecs[i].exp);
      issue_read(addr_of(BASE, vecs[i].idx), 8'd1);
      drain();
    end

    // Read burst of 2: beats at accept+4/+5, busy through accept+5.
    exp_q.push_back(model[4]);
    exp_q.push_back(model[5]);
    issue_read(addr_of(BASE, 4), 8'd2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("rd2_ready_k%0d", k), 64'(ifc.DDRAM_DOUT_READY), 64'((k == 4) || (k == 5)));
      chk($sformatf("rd2_busy_k%0d", k), 64'(ifc.DDRAM_BUSY), 64'(k <= 5));
    end
    drain();

    // Write burst of 3 at 1022 with two stalled cycles; must wrap to word 0.
    wait_not_busy();
    ifc.DDRAM_WE = 1'b1; ifc.DDRAM_ADDR = addr_of(BASE, 1022); ifc.DDRAM_BURSTCNT = 8'd3;
    ifc.DDRAM_DIN = 64'hB0B0_0000_0000_1022; ifc.DDRAM_BE = 8'hFF;
    step();
    ifc.DDRAM_WE = 1'b0; stall = 1'b1;
    step();
    ifc.DDRAM_WE = 1'b1; ifc.DDRAM_DIN = 64'hB1B1_0000_0000_1023;
    ifc.DDRAM_ADDR = addr_of(BASE, 500); ifc.DDRAM_BURSTCNT = 8'd9;
    @(negedge clk);
    chk("stall_busy_a", 64'(ifc.DDRAM_BUSY), 64'd1);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("stall_busy_b", 64'(ifc.DDRAM_BUSY), 64'd1);
    step();
    @(negedge clk);
    chk("stall_release", 64'(ifc.DDRAM_BUSY), 64'd0);
    step();
    ifc.DDRAM_DIN = 64'hB2B2_0000_0000_0000;
    step();
    ifc.DDRAM_WE = 1'b0;
    @(negedge clk);
    chk("wburst_idle", 64'(state_dbg), 64'(IDLE));
    model[1022] = 64'hB0B0_0000_0000_1022;
    model[1023] = 64'hB1B1_0000_0000_1023;
    model[0]    = 64'hB2B2_0000_0000_0000;
    for (int j = 0; j < 3; j++) exp_q.push_back(model[(1022 + j) % 1024]);
    issue_read(addr_of(BASE, 1022), 8'd3);
    drain();

    // RD and WE together: write kept, read dropped, one-cycle err.
    wait_not_busy();
    ifc.DDRAM_RD = 1'b1; ifc.DDRAM_WE = 1'b1; ifc.DDRAM_ADDR = addr_of(BASE, 200);
    ifc.DDRAM_BURSTCNT = 8'd1; ifc.DDRAM_DIN = 64'h0C0F_11C7_0000_0200; ifc.DDRAM_BE = 8'hFF;
    step();
    ifc.DDRAM_RD = 1'b0; ifc.DDRAM_WE = 1'b0;
    @(negedge clk);
    chk("conflict_err", 64'(err), 64'd1);
    chk("conflict_state", 64'(state_dbg), 64'(IDLE));
    step();
    @(negedge clk);
    chk("conflict_err_clr", 64'(err), 64'd0);
    repeat (8) step();
    model[200] = 64'h0C0F_11C7_0000_0200;
    exp_q.push_back(model[200]);
    issue_read(addr_of(BASE, 200), 8'd1);
    drain();

    // Out-of-window read of 2: zero data and one err pulse.
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    issue_read(addr_of(4'b0001, 3), 8'd2);
    @(negedge clk);
    chk("oow_err", 64'(err), 64'd1);
    step();
    @(negedge clk);
    chk("oow_err_clr", 64'(err), 64'd0);
    drain();

    // Out-of-window write: consumed, memory unchanged.
    write_single(addr_of(4'b1000, 16), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    @(negedge clk);
    chk("oow_wr_err", 64'(err), 64'd1);
    exp_q.push_back(model[16]);
    issue_read(addr_of(BASE, 16), 8'd1);
    drain();

    // Reset during beat 1 of a 4-beat read: remaining beats lost.
    exp_q.push_back(model[4]);
    exp_q.push_back(model[5]);
    issue_read(addr_of(BASE, 4), 8'd4);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ifc.DDRAM_DOUT_READY), 64'd0);
    chk("midrst_busy", 64'(ifc.DDRAM_BUSY), 64'd0);
    chk("midrst_state", 64'(state_dbg), 64'(IDLE));
    chk("midrst_left", 64'(exp_q.size()), 64'd0);
    repeat (6) step();

    // Burst count 0 is one beat.
    exp_q.push_back(model[100]);
    issue_read(addr_of(BASE, 100), 8'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
